ab_seq_tx: RTL and testbench

AB_SEQ_TX -- requirements
Module: ab_seq_tx

---
 rtl/ab_seq_pkg.sv | 21 ++
 rtl/ab_seq_chk.sv | 58 +++++
 rtl/ab_seq_tx.sv | 161 ++++++++++++++++
 tb/tb_ab_seq_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ab_seq_pkg.sv
// -----------------------------------------------------------------------------
// ab_seq_pkg
// Shared definitions for the a,b sequence transmitter.
//   state_e : FSM state encoding (five states, so three bits are needed)
//   MIN_GAP : minimum number of idle cycles between two a,b sequences
// -----------------------------------------------------------------------------
package ab_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_SEND_B = 3'd2,
        ST_GAP    = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

    // A downstream a-then-b detector needs at least one quiet cycle to
    // return to idle before it sees the next a.
    localparam int unsigned MIN_GAP = 32'd1;

endpackage : ab_seq_pkg

// File: rtl/ab_seq_chk.sv
// -----------------------------------------------------------------------------
// ab_seq_chk
// Sticky protocol checker for the loop-back signal q of ab_seq_tx.
// q is expected to be 1 exactly in the cycle after each b pulse and 0 in
// every other busy cycle.
// Ports:
//   clk_i       : clock
//   rst_n_i     : synchronous active-low reset
//   start_acc_i : burst start accepted this cycle (clears err)
//   b_i         : current value of the transmitter output b
//   busy_i      : current value of the transmitter output busy
//   q_i         : loop-back from the downstream detector
//   err_o       : sticky error flag (registered)
// -----------------------------------------------------------------------------
module ab_seq_chk (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_acc_i,
    input  logic b_i,
    input  logic busy_i,
    input  logic q_i,
    output logic err_o
);

    logic prev_b_q;
    logic prev_b_d;
    logic err_q;
    logic err_d;

    // Error next-state: an accepted start wins over any error detected in the same cycle.
    always_comb begin
        prev_b_d = b_i;
        err_d    = err_q;
        if (start_acc_i) begin
            err_d = 1'b0;
        end else if (prev_b_q && !q_i) begin
            err_d = 1'b1;
        end else if (!prev_b_q && q_i && busy_i) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Checker registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prev_b_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_b_q <= prev_b_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;

endmodule : ab_seq_chk

// File: rtl/ab_seq_tx.sv
// -----------------------------------------------------------------------------
// ab_seq_tx
// Emits a burst of "count" a,b sequences (a for one cycle, then b for one
// cycle), separated by gap+MIN_GAP idle cycles, followed by a one-cycle done.
// Ports:
//   clock : single clock, rising edge
//   reset : synchronous active-low reset
//   start : burst request, sampled only while idle
//   count : number of a,b sequences (sampled with start)
//   gap   : extra idle cycles between sequences (sampled with start)
//   abort : ends a running burst at the next edge, no done pulse
//   a, b  : registered sequence symbols (never both high)
//   busy  : high while a burst is running, including the done cycle
//   done  : one-cycle pulse at normal completion
// Optional build macro AB_SEQ_TX_CHECK_EN adds:
//   q     : loop-back from a downstream a-then-b detector
//   err   : sticky protocol error flag
// -----------------------------------------------------------------------------
module ab_seq_tx
    import ab_seq_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int GAP_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done
`ifdef AB_SEQ_TX_CHECK_EN
    ,
    input  logic             q,
    output logic             err
`endif
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic [GAP_W-1:0] gcnt_q;
    logic [GAP_W-1:0] gcnt_d;
    logic             a_q;
    logic             a_d;
    logic             b_q;
    logic             b_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             start_acc_s;

    // Next-state logic; outputs are decoded from the next state so that the
    // output flops line up with the state register.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        gcnt_d      = gcnt_q;
        start_acc_s = (state_q == ST_IDLE) && start && !abort;

        if ((state_q != ST_IDLE) && abort) begin
            state_d = ST_IDLE;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        rem_d   = count;
                        gap_d   = gap;
                        gcnt_d  = '0;
                        state_d = (count == '0) ? ST_FIN : ST_SEND_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEND_A: begin
                    state_d = ST_SEND_B;
                end
                ST_SEND_B: begin
                    // count is unsigned and non-zero here, so the all-ones
                    // value simply counts down like any other.
                    rem_d  = rem_q - CNT_W'(1);
                    gcnt_d = '0;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    // gcnt runs 0 .. gap+MIN_GAP-1, giving gap+MIN_GAP idle cycles.
                    if (gcnt_q == (gap_q + GAP_W'(MIN_GAP - 32'd1))) begin
                        state_d = ST_SEND_A;
                    end else begin
                        gcnt_d = gcnt_q + GAP_W'(1);
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        a_d    = (state_d == ST_SEND_A);
        b_d    = (state_d == ST_SEND_B);
        done_d = (state_d == ST_FIN);
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef AB_SEQ_TX_CHECK_EN
    ab_seq_chk u_chk (
        .clk_i       (clock),
        .rst_n_i     (reset),
        .start_acc_i (start_acc_s),
        .b_i         (b_q),
        .busy_i      (busy_q),
        .q_i         (q),
        .err_o       (err)
    );
`endif

endmodule : ab_seq_tx

// File: tb/tb_ab_seq_tx.sv
// -----------------------------------------------------------------------------
// tb_ab_seq_tx
// Self-checking bench for ab_seq_tx. Expected waveforms are built per burst
// from the sequence rules (a, b, gap idles, done) and compared every cycle.
// -----------------------------------------------------------------------------
module tb_ab_seq_tx;

    localparam int CNT_W = 4;
    localparam int GAP_W = 2;

    logic             clock;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;

    int checks;
    int failures;

    // Expected {a,b,busy,done} per cycle after the accepting edge.
    logic [3:0] exp_q[$];

`ifdef AB_SEQ_TX_CHECK_EN
    logic q;
    logic err;
    logic q_sel;
    logic saw_a;
    logic q_det;

    // Reference a-then-b detector: q=1 in the cycle after an a followed by b.
    always_ff @(posedge clock) begin
        saw_a <= a;
        q_det <= saw_a & b;
    end
    assign q = q_sel ? q_det : 1'b0;
`endif

    ab_seq_tx #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .count (count),
        .gap   (gap),
        .abort (abort),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done)
`ifdef AB_SEQ_TX_CHECK_EN
        ,
        .q     (q),
        .err   (err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Burst of n sequences: (a)(b) then gap+1 idles between sequences, then done.
    task automatic build_exp(input int n, input int g);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(4'b1010);
            exp_q.push_back(4'b0110);
            if (i < n - 1) begin
                for (int j = 0; j < g + 1; j++) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0011);
    endtask

    function automatic logic [31:0] outs();
        return 32'({a, b, busy, done});
    endfunction

    // mode 0: normal; 1: abort after checking cycle index 'at'; 2: reset there.
    task automatic run_burst(input int n, input int g, input int mode, input int at);
        build_exp(n, g);
        start = 1'b1;
        count = CNT_W'(n);
        gap   = GAP_W'(g);
        abort = 1'b0;
        tick();
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("burst n=%0d g=%0d cyc=%0d", n, g, k + 1), outs(), 32'(exp_q[k]));
            check("a_b_exclusive", 32'(a & b), 32'd0);
            if (k == at && mode == 1) begin
                abort = 1'b1;
                start = 1'($urandom_range(0, 1));
                tick();
                abort = 1'b0;
                start = 1'b0;
                check("abort_outputs", outs(), 32'd0);
                tick();
                check("abort_no_done", outs(), 32'd0);
                return;
            end
            if (k == at && mode == 2) begin
                reset = 1'b0;
                start = 1'b1;
                tick();
                reset = 1'b1;
                start = 1'b0;
                check("reset_mid_burst", outs(), 32'd0);
                tick();
                check("reset_start_ignored", outs(), 32'd0);
                return;
            end
            // Activity on start/count/gap while busy must not disturb the burst.
            start = 1'($urandom_range(0, 1));
            count = CNT_W'($urandom);
            gap   = GAP_W'($urandom);
            tick();
        end
        start = 1'b0;
        check($sformatf("idle_after n=%0d g=%0d", n, g), outs(), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b1;
        count    = CNT_W'(3);
        gap      = GAP_W'(0);
        abort    = 1'b0;
`ifdef AB_SEQ_TX_CHECK_EN
        q_sel    = 1'b1;
`endif
        tick();
        tick();
        check("reset_state", outs(), 32'd0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        check("reset_start_dropped", outs(), 32'd0);

        // Directed bursts: single sequence, spaced triple, empty, maximum count.
        run_burst(1, 0, 0, -1);
        run_burst(3, 2, 0, -1);
        run_burst(0, 1, 0, -1);
        run_burst(15, 3, 0, -1);

        // Abort in the cycle after the second a (index 5 with gap=1), then restart.
        run_burst(3, 1, 1, 5);
        run_burst(2, 0, 0, -1);

        // start together with abort in idle: request dropped.
        start = 1'b1;
        abort = 1'b1;
        count = CNT_W'(2);
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_dropped", outs(), 32'd0);
        tick();
        check("start_abort_still_idle", outs(), 32'd0);

        // Reset in the middle of a gap, with start on the same edge.
        run_burst(2, 2, 2, 3);
        run_burst(1, 1, 0, -1);

        // Randomized bursts with random idle spacing.
        for (int r = 0; r < 20; r++) begin
            int n;
            int g;
            int idle;
            n    = int'($urandom_range(0, 15));
            g    = int'($urandom_range(0, 3));
            idle = int'($urandom_range(0, 3));
            run_burst(n, g, 0, -1);
            for (int i = 0; i < idle; i++) begin
                tick();
                check("random_idle", outs(), 32'd0);
            end
        end

`ifdef AB_SEQ_TX_CHECK_EN
        q_sel = 1'b1;
        run_burst(3, 1, 0, -1);
        check("err_loopback_clean", 32'(err), 32'd0);
        q_sel = 1'b0;
        run_burst(2, 0, 0, -1);
        check("err_q_tied_low", 32'(err), 32'd1);
        q_sel = 1'b1;
        run_burst(2, 2, 0, -1);
        check("err_cleared_by_start", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ab_seq_tx
